// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
//  exec_pkg : shared encodings for the execute stage and its ALU
//  Revision : 1.0
// ============================================================================
package exec_pkg;

    typedef enum logic [2:0] {
        KIND_ALU_RR = 3'd0,
        KIND_ALU_RI = 3'd1,
        KIND_BRANCH = 3'd2,
        KIND_JAL    = 3'd3,
        KIND_JALR   = 3'd4,
        KIND_LUI    = 3'd5,
        KIND_AUIPC  = 3'd6,
        KIND_SLT    = 3'd7
    } kind_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SRA = 3'd7
    } alu_op_e;

    localparam logic [2:0] C_F3_BEQ  = 3'b000;
    localparam logic [2:0] C_F3_BNE  = 3'b001;
    localparam logic [2:0] C_F3_BLT  = 3'b100;
    localparam logic [2:0] C_F3_BGE  = 3'b101;
    localparam logic [2:0] C_F3_BLTU = 3'b110;
    localparam logic [2:0] C_F3_BGEU = 3'b111;

    localparam int C_ST_EQ  = 0;
    localparam int C_ST_LT  = 1;
    localparam int C_ST_LTU = 2;

    function automatic logic is_shift(input alu_op_e op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ALU.sv
`default_nettype none
// ============================================================================
//  ALU : 32-bit combinational ALU with eq / lt / ltu status bits
//  Revision : 1.0
// ============================================================================
module ALU
    import exec_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] result,
    output logic [2:0]  status
);

    // Shifts use the full b operand; amounts of 32 or more saturate.
    always_comb begin
        result = 32'd0;
        case (alu_op_e'(op))
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = a << b;
            ALU_SRL: result = a >> b;
            ALU_SRA: result = $unsigned($signed(a) >>> b);
            default: result = 32'd0;
        endcase
    end

    always_comb begin
        status           = 3'b000;
        status[C_ST_EQ]  = (a == b);
        status[C_ST_LT]  = ($signed(a) < $signed(b));
        status[C_ST_LTU] = (a < b);
    end

endmodule
`default_nettype wire

// File: rtl/exec_stage.sv
`default_nettype none
// ============================================================================
//  exec_stage : RISC-V execute stage, S1 operand latch -> ALU -> S2 result
//               latch, valid/ready on both sides. EXEC_SLT_EN enables kind 7.
//  Revision   : 1.0
// ============================================================================
module exec_stage
    import exec_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_kind,
    input  logic [2:0]      in_alu_op,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [RA_W-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RA_W-1:0] out_rd,
    output logic            out_wb_en,
    output logic            out_redirect,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    logic            r_s1_valid;
    kind_e           r_kind;
    alu_op_e         r_alu_op;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_pc, r_rs1, r_rs2, r_imm;
    logic [RA_W-1:0] r_rd;

    logic            r_s2_valid;
    logic [XLEN-1:0] r_result, r_target;
    logic [RA_W-1:0] r_out_rd;
    logic            r_wb_en, r_redirect, r_illegal;

    logic            w_s1_advance;
    logic [XLEN-1:0] w_a, w_b, w_alu_out, w_pc_plus4, w_pc_imm;
    alu_op_e         w_op;
    logic [2:0]      w_status;
    logic [XLEN-1:0] w_result, w_target;
    logic            w_taken, w_redirect, w_illegal, w_wb_en;

    assign w_s1_advance = !r_s2_valid || out_ready;
    assign in_ready     = !flush && (!r_s1_valid || w_s1_advance);

    assign w_pc_plus4 = r_pc + XLEN'(4);
    assign w_pc_imm   = r_pc + r_imm;

    // Operand mux; shift amounts are cut to 5 bits before reaching the ALU.
    always_comb begin
        w_a  = r_rs1;
        w_b  = r_rs2;
        w_op = ALU_ADD;
        case (r_kind)
            KIND_ALU_RR: begin
                w_op = r_alu_op;
                if (is_shift(r_alu_op)) w_b = {{(XLEN-5){1'b0}}, r_rs2[4:0]};
            end
            KIND_ALU_RI: begin
                w_op = r_alu_op;
                w_b  = is_shift(r_alu_op) ? {{(XLEN-5){1'b0}}, r_imm[4:0]} : r_imm;
            end
            KIND_BRANCH: w_op = ALU_SUB;
            KIND_JAL: begin
                w_a = '0;
                w_b = '0;
            end
            KIND_JALR:  w_b = r_imm;
            KIND_LUI: begin
                w_a = '0;
                w_b = r_imm;
            end
            KIND_AUIPC: begin
                w_a = r_pc;
                w_b = r_imm;
            end
`ifdef EXEC_SLT_EN
            KIND_SLT:   w_op = ALU_SUB;
`endif
            default: ;
        endcase
    end

    ALU u_alu (
        .a      (w_a),
        .b      (w_b),
        .op     (w_op),
        .result (w_alu_out),
        .status (w_status)
    );

    always_comb begin
        w_result   = w_alu_out;
        w_target   = w_pc_imm;
        w_taken    = 1'b0;
        w_redirect = 1'b0;
        w_illegal  = 1'b0;
        case (r_kind)
            KIND_BRANCH: begin
                case (r_funct3)
                    C_F3_BEQ:  w_taken =  w_status[C_ST_EQ];
                    C_F3_BNE:  w_taken = !w_status[C_ST_EQ];
                    C_F3_BLT:  w_taken =  w_status[C_ST_LT];
                    C_F3_BGE:  w_taken = !w_status[C_ST_LT];
                    C_F3_BLTU: w_taken =  w_status[C_ST_LTU];
                    C_F3_BGEU: w_taken = !w_status[C_ST_LTU];
                    default:   w_illegal = 1'b1;
                endcase
                w_redirect = w_taken;
            end
            KIND_JAL: begin
                w_result   = w_pc_plus4;
                w_redirect = 1'b1;
            end
            KIND_JALR: begin
                w_result   = w_pc_plus4;
                w_target   = {w_alu_out[XLEN-1:1], 1'b0};
                w_redirect = 1'b1;
            end
            KIND_SLT: begin
`ifdef EXEC_SLT_EN
                w_result = {{(XLEN-1){1'b0}},
                            r_funct3[0] ? w_status[C_ST_LTU] : w_status[C_ST_LT]};
`else
                w_result  = '0;
                w_illegal = 1'b1;
`endif
            end
            default: ;
        endcase
        w_wb_en = (r_kind != KIND_BRANCH) && (r_rd != '0) && !w_illegal;
    end

    // S1 refills whenever it is empty or its content moves to S2 this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_kind     <= KIND_ALU_RR;
            r_alu_op   <= ALU_ADD;
            r_funct3   <= 3'd0;
            r_pc       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_imm      <= '0;
            r_rd       <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (!r_s1_valid || w_s1_advance) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_kind   <= kind_e'(in_kind);
                r_alu_op <= alu_op_e'(in_alu_op);
                r_funct3 <= in_funct3;
                r_pc     <= in_pc;
                r_rs1    <= in_rs1;
                r_rs2    <= in_rs2;
                r_imm    <= in_imm;
                r_rd     <= in_rd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_target   <= '0;
            r_out_rd   <= '0;
            r_wb_en    <= 1'b0;
            r_redirect <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s1_advance) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result   <= w_result;
                r_target   <= w_target;
                r_out_rd   <= r_rd;
                r_wb_en    <= w_wb_en;
                r_redirect <= w_redirect;
                r_illegal  <= w_illegal;
            end
        end
    end

    assign out_valid    = r_s2_valid;
    assign out_result   = r_result;
    assign out_target   = r_target;
    assign out_rd       = r_out_rd;
    assign out_wb_en    = r_wb_en;
    assign out_redirect = r_redirect;
    assign out_illegal  = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_exec_stage.sv
`default_nettype none
// ============================================================================
//  tb_exec_stage : directed vectors with a scoreboard queue and output monitor
//  Revision      : 1.0
// ============================================================================
module tb_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_kind, in_alu_op, in_funct3;
    logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
    logic [4:0]  in_rd;
    logic        out_valid, out_ready;
    logic [31:0] out_result, out_target;
    logic [4:0]  out_rd;
    logic        out_wb_en, out_redirect, out_illegal;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wb;
        logic        redir;
        logic [31:0] tgt;
        logic        ill;
        logic        chk_res;
        logic        chk_tgt;
    } exp_t;

    exp_t sb[$];

    exec_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_kind      (in_kind),
        .in_alu_op    (in_alu_op),
        .in_funct3    (in_funct3),
        .in_pc        (in_pc),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_imm       (in_imm),
        .in_rd        (in_rd),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_rd       (out_rd),
        .out_wb_en    (out_wb_en),
        .out_redirect (out_redirect),
        .out_target   (out_target),
        .out_illegal  (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output record is matched against the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: result 0x%08h with empty scoreboard", out_result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk_res) chk("result", out_result, e.res);
                chk("rd",       {27'd0, out_rd},       {27'd0, e.rd});
                chk("wb_en",    {31'd0, out_wb_en},    {31'd0, e.wb});
                chk("redirect", {31'd0, out_redirect}, {31'd0, e.redir});
                chk("illegal",  {31'd0, out_illegal},  {31'd0, e.ill});
                if (e.chk_tgt) chk("target", out_target, e.tgt);
            end
        end
    end

    task automatic send(input logic [2:0] kind, input logic [2:0] op, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic [4:0] rd,
                        input logic [31:0] eres, input logic ewb, input logic eredir,
                        input logic [31:0] etgt, input logic eill,
                        input logic cres, input logic ctgt);
        exp_t e;
        bit   got;
        in_valid  = 1'b1;
        in_kind   = kind;
        in_alu_op = op;
        in_funct3 = f3;
        in_pc     = pc;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        in_rd     = rd;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready stayed 0 for 50 cycles");
        end else begin
            e.res = eres; e.rd = rd; e.wb = ewb; e.redir = eredir;
            e.tgt = etgt; e.ill = eill; e.chk_res = cres; e.chk_tgt = ctgt;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_out_valid"}, {31'd0, out_valid},    32'd0);
        chk({tag, "_result"},    out_result,            32'd0);
        chk({tag, "_target"},    out_target,            32'd0);
        chk({tag, "_rd"},        {27'd0, out_rd},       32'd0);
        chk({tag, "_wb_en"},     {31'd0, out_wb_en},    32'd0);
        chk({tag, "_redirect"},  {31'd0, out_redirect}, 32'd0);
        chk({tag, "_illegal"},   {31'd0, out_illegal},  32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_kind = 3'd0; in_alu_op = 3'd0; in_funct3 = 3'd0;
        in_pc = 32'd0; in_rs1 = 32'd0; in_rs2 = 32'd0; in_imm = 32'd0; in_rd = 5'd0;
        #1;
        check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // kind op f3 pc rs1 rs2 imm rd | res wb redir tgt ill chk_res chk_tgt
        send(3'd0, 3'd1, 3'd0, 32'h0, 32'd5, 32'd7, 32'h0, 5'd3,  32'hFFFFFFFE, 1, 0, 32'h0, 0, 1, 0);
        send(3'd2, 3'd0, 3'd4, 32'h100, 32'hFFFFFFFF, 32'd1, 32'h20, 5'd0, 32'h0, 0, 1, 32'h120, 0, 0, 1);
        send(3'd2, 3'd0, 3'd6, 32'h100, 32'hFFFFFFFF, 32'd1, 32'h20, 5'd0, 32'h0, 0, 0, 32'h120, 0, 0, 1);
        send(3'd4, 3'd0, 3'd0, 32'h40, 32'h1003, 32'h0, 32'h4, 5'd1, 32'h44, 1, 1, 32'h1006, 0, 1, 1);
        send(3'd4, 3'd0, 3'd0, 32'h40, 32'h1003, 32'h0, 32'h4, 5'd0, 32'h44, 0, 1, 32'h1006, 0, 1, 1);
        send(3'd0, 3'd5, 3'd0, 32'h0, 32'h1, 32'h23, 32'h0, 5'd5, 32'h8, 1, 0, 32'h0, 0, 1, 0);
        send(3'd1, 3'd7, 3'd0, 32'h0, 32'h80000000, 32'h0, 32'h21, 5'd6, 32'hC0000000, 1, 0, 32'h0, 0, 1, 0);
        send(3'd2, 3'd0, 3'd2, 32'h100, 32'h1, 32'h1, 32'h20, 5'd4, 32'h0, 0, 0, 32'h0, 1, 0, 0);
        send(3'd3, 3'd0, 3'd0, 32'h200, 32'h0, 32'h0, 32'hFFFFFFF8, 5'd1, 32'h204, 1, 1, 32'h1F8, 0, 1, 1);
        send(3'd5, 3'd0, 3'd0, 32'h0, 32'h55, 32'h0, 32'h12345000, 5'd7, 32'h12345000, 1, 0, 32'h0, 0, 1, 0);
        send(3'd6, 3'd0, 3'd0, 32'h1000, 32'h0, 32'h0, 32'h2000, 5'd8, 32'h3000, 1, 0, 32'h0, 0, 1, 0);
        send(3'd2, 3'd0, 3'd0, 32'hFFFFFFF0, 32'd9, 32'd9, 32'h20, 5'd0, 32'h0, 0, 1, 32'h10, 0, 0, 1);
        send(3'd2, 3'd0, 3'd1, 32'h0, 32'd9, 32'd9, 32'h20, 5'd0, 32'h0, 0, 0, 32'h20, 0, 0, 1);
        send(3'd2, 3'd0, 3'd5, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h8, 5'd0, 32'h0, 0, 0, 32'h8, 0, 0, 1);
        send(3'd2, 3'd0, 3'd7, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h8, 5'd0, 32'h0, 0, 1, 32'h8, 0, 0, 1);
`ifdef EXEC_SLT_EN
        send(3'd7, 3'd0, 3'd0, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h0, 5'd9, 32'h1, 1, 0, 32'h0, 0, 1, 0);
        send(3'd7, 3'd0, 3'd1, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h0, 5'd9, 32'h0, 1, 0, 32'h0, 0, 1, 0);
`else
        send(3'd7, 3'd0, 3'd0, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h0, 5'd9, 32'h0, 0, 0, 32'h0, 1, 1, 0);
        send(3'd7, 3'd0, 3'd1, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h0, 5'd9, 32'h0, 0, 0, 32'h0, 1, 1, 0);
`endif

        // Back-to-back stream with out_ready held low for three edges.
        fork
            begin
                send(3'd0, 3'd0, 3'd0, 32'h0, 32'd1,   32'd2,   32'h0, 5'd9,  32'h3,  1, 0, 32'h0, 0, 1, 0);
                send(3'd0, 3'd4, 3'd0, 32'h0, 32'hF0, 32'hFF, 32'h0, 5'd10, 32'h0F, 1, 0, 32'h0, 0, 1, 0);
                send(3'd0, 3'd2, 3'd0, 32'h0, 32'hF0, 32'h3C, 32'h0, 5'd11, 32'h30, 1, 0, 32'h0, 0, 1, 0);
                send(3'd0, 3'd3, 3'd0, 32'h0, 32'hF0, 32'h0F, 32'h0, 5'd12, 32'hFF, 1, 0, 32'h0, 0, 1, 0);
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("stall_in_ready",  {31'd0, in_ready},  32'd0);
                    chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
                    chk("stall_hold",      out_result,         32'h3);
                    @(posedge clk);
                end
                #1 out_ready = 1'b1;
            end
        join
        for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
        chk("stream_drained", sb.size(), 32'd0);

        // Flush with both slots occupied.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(3'd0, 3'd0, 3'd0, 32'h0, 32'd4, 32'd4, 32'h0, 5'd2, 32'h8, 1, 0, 32'h0, 0, 1, 0);
        send(3'd0, 3'd0, 3'd0, 32'h0, 32'd6, 32'd6, 32'h0, 5'd2, 32'hC, 1, 0, 32'h0, 0, 1, 0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        sb.delete();
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("flush_ready_again", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a stall.
        send(3'd3, 3'd0, 3'd0, 32'h300, 32'h0, 32'h0, 32'h10, 5'd2, 32'h304, 1, 1, 32'h310, 0, 1, 1);
        send(3'd0, 3'd0, 3'd0, 32'h0, 32'd1, 32'd1, 32'h0, 5'd2, 32'h2, 1, 0, 32'h0, 0, 1, 0);
        chk("prereset_redirect", {31'd0, out_redirect}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        send(3'd0, 3'd6, 3'd0, 32'h0, 32'h80, 32'h24, 32'h0, 5'd13, 32'h8, 1, 0, 32'h0, 0, 1, 0);
        for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
        chk("final_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exec_stage.md
# exec_stage

Execute stage of the RISC-V core, sitting between decode and writeback. Accepts one decoded instruction per cycle over a valid/ready handshake, drives an internal `ALU` instance, resolves branches and jumps from the ALU status bits, and presents a registered writeback/redirect record downstream. Two register slots (S1 operand latch, S2 result latch) give full throughput with backpressure.

## Interface
- `XLEN`, 32: datapath width; only 32 is legal because the ALU is fixed at 32.
- `RA_W`, 5: register-address width.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous kill of S1 and S2.
- `in_valid` in 1 / `in_ready` out 1: upstream handshake.
- `in_kind` in 3: 0 ALU_RR, 1 ALU_RI, 2 BRANCH, 3 JAL, 4 JALR, 5 LUI, 6 AUIPC, 7 SLT.
- `in_alu_op` in 3: ALU op code (ADD0 SUB1 AND2 OR3 XOR4 SLL5 SRL6 SRA7); used for ALU_RR/ALU_RI.
- `in_funct3` in 3: branch condition; bit0 selects SLTU for SLT.
- `in_pc`, `in_rs1`, `in_rs2`, `in_imm` in 32 each: PC, operands, sign-extended immediate.
- `in_rd` in `RA_W`: destination register.
- `out_valid` out 1 / `out_ready` in 1: downstream handshake.
- `out_result` out 32, `out_rd` out `RA_W`, `out_wb_en` out 1: writeback record.
- `out_redirect` out 1, `out_target` out 32: taken branch/jump and destination.
- `out_illegal` out 1: kind/funct3 not executable.

## Operation
- S1 captures the input on `in_valid && in_ready`. `in_ready = !flush && (!s1_valid || s1_advance)`, where `s1_advance = !s2_valid || out_ready`.
- The ALU reads S1 combinationally. Operand mux:
  - ALU_RR: a=rs1, b=rs2.
  - ALU_RI: a=rs1, b=imm.
  - BRANCH: a=rs1, b=rs2, op SUB.
  - JALR: a=rs1, b=imm, ADD.
  - LUI: a=0, b=imm, ADD.
  - AUIPC: a=pc, b=imm, ADD.
  - SLT: a=rs1, b=rs2 (b=imm when the decoder supplies it in `in_rs2`), op SUB.
  - JAL: ALU unused.
- For ALU_RR/ALU_RI with op SLL/SRL/SRA, b is masked to bits[4:0] before the ALU.
- Result:
  - ALU kinds, LUI, AUIPC: ALU out.
  - JAL, JALR: pc+4 (separate adder).
  - SLT: `{31'b0, status[1]}`; SLTU: `{31'b0, status[2]}`.
- Branch condition from funct3, using status[0]=eq, [1]=lt signed, [2]=lt unsigned:
  - 000 eq; 001 !eq; 100 lt; 101 !lt; 110 ltu; 111 !ltu.
  - 010/011: not taken, `out_illegal=1`.
- Target:
  - BRANCH, JAL: pc+imm (dedicated adder, wraps mod 2^32).
  - JALR: ALU out & ~1.
- `out_redirect`: taken BRANCH, JAL, JALR.
- `out_wb_en`: 1 for every kind except BRANCH; forced 0 when rd==0 or illegal.
- S2 captures the computed record on `s1_valid && s1_advance`.
- No self-squash: downstream observes `out_redirect` and asserts `flush`.

## Timing
- Latency: input accepted at edge N; record is in S2 with `out_valid=1` after edge N+1. Throughput is 1/cycle.
- While `out_valid && !out_ready`, all out_* are held stable; S1 holds; `in_ready` is low when S1 is full.
- Simultaneous S2 drain and S1 advance in the same cycle is legal (no bubble).
- `flush`: at the edge, clears s1_valid and s2_valid; `in_ready=0` during flush, so no input is accepted. Flush has priority over every capture.
- Reset (asynchronous, any time including mid-stall): s1_valid=s2_valid=0; out_result, out_target, out_rd = 0; out_wb_en, out_redirect, out_illegal = 0; `in_ready` reads 1 after release.

## Configuration
- `EXEC_SLT_EN` defined: kind 7 executes SLT/SLTU as above.
- `EXEC_SLT_EN` undefined: kind 7 is illegal: `out_illegal=1`, `out_wb_en=0`, `out_redirect=0`, `out_result=0`; the SLT mux logic is not built.

## Structure
- Shared package `exec_pkg`: kind encodings, ALU op codes (matching the ALU), branch funct3 codes, status bit indices.
- One sub-module: `ALU` instance (existing block), driven by the S1 operand mux. All other logic stays inline.

## Test plan
- ALU_RR SUB, rs1=5, rs2=7, rd=3 → after 2 cycles `out_result=0xFFFFFFFE`, `out_wb_en=1`, `out_rd=3`.
- BLT rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 → `out_redirect=1`, `out_target=0x120`. BLTU with the same operands → `out_redirect=0`.
- JALR rs1=0x1003, imm=4, pc=0x40, rd=1 → `out_target=0x1006`, `out_result=0x44`. Same with rd=0 → `out_wb_en=0`.
- SLL rs1=1, rs2=0x23 → `out_result=0x8`, confirming the shift amount is masked to 5 bits.
- Stream of 4 back-to-back ops with `out_ready` low for 3 cycles mid-stream → no loss, no duplication, in order, `in_ready` low while S1 and S2 are full.
- `flush` with S1 and S2 full → `out_valid=0` the next cycle. SLT kind with the macro undefined → `out_illegal=1`. `rst_n` low during a stall → all outputs zero immediately.
